// File: rtl/round_pkg.sv
// Shared constants and width helpers for the round-and-saturate datapath.
package round_pkg;

  localparam logic [1:0] MODE_TRUNC = 2'd0;
  localparam logic [1:0] MODE_RHU   = 2'd1;
  localparam logic [1:0] MODE_RNE   = 2'd2;

  // Fraction bits dropped: everything below the output LSB plus the redundant sign bit.
  function automatic int frac_bits(input int in_w, input int out_w);
    return in_w - 1 - out_w;
  endfunction

  function automatic bit widths_ok(input int in_w, input int out_w);
    return in_w >= out_w + 2;
  endfunction

endpackage

// File: rtl/round_lane.sv
// One lane: rounding of a signed product (i_x -> o_r) and symmetric clamp (i_r -> o_data/o_sat).
// The two halves are independent so the pipeline can register between them.
module round_lane
  import round_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]  i_x,
  input  logic [1:0]       i_mode,
  output logic [OUT_W+1:0] o_r,
  input  logic [OUT_W+1:0] i_r,
  output logic [OUT_W-1:0] o_data,
  output logic             o_sat
);

  localparam int F  = frac_bits(IN_W, OUT_W);
  localparam int RW = OUT_W + 2;

  localparam logic [IN_W:0] HALF_E = (IN_W+1)'(1 << (F-1));
  localparam logic [F-1:0]  HALF_F = F'(1 << (F-1));
  localparam logic signed [RW-1:0] MAX_R = RW'((1 << (OUT_W-1)) - 1);
  localparam logic signed [RW-1:0] MIN_R = -MAX_R;

  logic [RW-1:0]   w_floor;
  logic [IN_W:0]   w_sum;
  logic [RW-1:0]   w_rhu;
  logic [RW-1:0]   w_rne;
  logic [F-1:0]    w_frac;
  logic            w_up_rne;
  logic signed [RW-1:0] w_rs;

  // Slicing off the low F bits of a sign-extended value is an arithmetic shift right.
  assign w_floor  = {i_x[IN_W-1], i_x[IN_W-1:F]};
  assign w_sum    = {i_x[IN_W-1], i_x} + HALF_E;
  assign w_rhu    = w_sum[IN_W:F];
  assign w_frac   = i_x[F-1:0];
  assign w_up_rne = (w_frac > HALF_F) | ((w_frac == HALF_F) & w_floor[0]);
  assign w_rne    = w_floor + {{(RW-1){1'b0}}, w_up_rne};

  always_comb begin
    case (i_mode)
      MODE_TRUNC: o_r = w_floor;
      MODE_RNE:   o_r = w_rne;
      default:    o_r = w_rhu;
    endcase
  end

  assign w_rs = i_r;

  always_comb begin
    o_data = i_r[OUT_W-1:0];
    o_sat  = 1'b0;
    if (w_rs > MAX_R) begin
      o_data = MAX_R[OUT_W-1:0];
      o_sat  = 1'b1;
    end else if (w_rs < MIN_R) begin
      o_data = MIN_R[OUT_W-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage round/saturate pipeline with valid/ready on both sides and a sticky
// count of output beats that had any lane clamped.
module round_sat_pipe
  import round_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   sat_clear,
  output logic [CNT_W-1:0]       sat_count
);

  localparam int RW = OUT_W + 2;

  if (!widths_ok(IN_W, OUT_W)) begin : g_width_check
    $error("round_sat_pipe: IN_W must be at least OUT_W+2");
  end

  logic [LANES*RW-1:0]    w_r;
  logic [LANES*OUT_W-1:0] w_data;
  logic [LANES-1:0]       w_sat;
  logic                   w_s1_load;
  logic                   w_s2_load;
  logic                   w_inc;

  logic                   r_s1_valid;
  logic [LANES*RW-1:0]    r_s1_r;
  logic                   r_s2_valid;
  logic [LANES*OUT_W-1:0] r_out_data;
  logic [LANES-1:0]       r_out_sat;
  logic [CNT_W-1:0]       r_sat_count;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      round_lane #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_lane (
        .i_x    (in_data[gi*IN_W +: IN_W]),
        .i_mode (mode),
        .o_r    (w_r[gi*RW +: RW]),
        .i_r    (r_s1_r[gi*RW +: RW]),
        .o_data (w_data[gi*OUT_W +: OUT_W]),
        .o_sat  (w_sat[gi])
      );
    end
  endgenerate

  // Ready ripples back combinationally from out_ready so a full pipe still streams.
  assign w_s2_load = !r_s2_valid | out_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;
  assign w_inc     = r_s2_valid & out_ready & (|r_out_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_r <= w_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_data;
        r_out_sat  <= w_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (sat_clear) begin
      r_sat_count <= '0;
    end else if (w_inc && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed bench for round_sat_pipe (IN_W=8, OUT_W=4, F=3, MAX=7); one line per transaction.
module tb_round_sat_pipe;

  localparam logic [1:0] TRUNC = 2'd0;
  localparam logic [1:0] RHU   = 2'd1;
  localparam logic [1:0] RNE   = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_sat;
  logic        sat_clear = 1'b0;
  logic [15:0] sat_count;

  int n_checks = 0;
  int n_errors = 0;

  int          acc_win [6];
  int          nxt, got, occ;
  logic        acc, xf, prev_stall;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  round_sat_pipe #(.IN_W(8), .OUT_W(4), .LANES(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clear (sat_clear),
    .sat_count (sat_count)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Same product on all four lanes; expects the result 2 edges after presentation.
  task automatic beat(input string tag, input logic [7:0] x, input logic [1:0] m,
                      input logic [3:0] exp_nib, input logic exp_sat, input logic clr);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {4{x}};
    mode      = m;
    tick();
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = ~m;
    chk({tag, "/lat1"}, out_valid, 1'b0);
    tick();
    chk({tag, "/valid"}, out_valid, 1'b1);
    chk({tag, "/data"}, out_data, {4{exp_nib}});
    chk({tag, "/sat"}, out_sat, {4{exp_sat}});
    $display("beat %s x=%h mode=%0d -> data=%h sat=%h", tag, x, m, out_data, out_sat);
    sat_clear = clr;
    tick();
    sat_clear = 1'b0;
  endtask

  initial begin
    // Reset state while rst_n is held low
    tick();
    tick();
    chk("rst/out_valid", out_valid, 1'b0);
    chk("rst/out_data", out_data, 16'h0000);
    chk("rst/out_sat", out_sat, 4'h0);
    chk("rst/sat_count", sat_count, 16'h0000);
    chk("rst/in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("rel/in_ready", in_ready, 1'b1);

    // Rounding modes
    beat("2C_trunc", 8'h2C, TRUNC, 4'h5, 1'b0, 1'b0);
    beat("2C_rhu",   8'h2C, RHU,   4'h6, 1'b0, 1'b0);
    beat("2C_rne",   8'h2C, RNE,   4'h6, 1'b0, 1'b0);
    beat("24_rne",   8'h24, RNE,   4'h4, 1'b0, 1'b0);
    beat("24_rhu",   8'h24, RHU,   4'h5, 1'b0, 1'b0);
    beat("24_mode3", 8'h24, 2'd3,  4'h5, 1'b0, 1'b0);
    beat("EC_rne",   8'hEC, RNE,   4'hE, 1'b0, 1'b0);
    beat("EC_trunc", 8'hEC, TRUNC, 4'hD, 1'b0, 1'b0);
    chk("cnt/after_round", sat_count, 16'd0);

    // Saturation and clamp
    beat("3C_rhu",   8'h3C, RHU,   4'h7, 1'b1, 1'b0);
    chk("cnt/pos_sat", sat_count, 16'd1);
    beat("3C_trunc", 8'h3C, TRUNC, 4'h7, 1'b0, 1'b0);
    chk("cnt/no_sat", sat_count, 16'd1);
    beat("C4_rhu",   8'hC4, RHU,   4'h9, 1'b0, 1'b0);
    beat("C4_trunc", 8'hC4, TRUNC, 4'h9, 1'b1, 1'b0);
    beat("C0_rhu",   8'hC0, RHU,   4'h9, 1'b1, 1'b0);
    beat("80_rne",   8'h80, RNE,   4'h9, 1'b1, 1'b0);
    chk("cnt/neg_sat", sat_count, 16'd4);

    // Counter clear, alone and colliding with an increment
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    chk("cnt/clear", sat_count, 16'd0);
    beat("cnt_a", 8'h3C, RHU, 4'h7, 1'b1, 1'b0);
    beat("cnt_b", 8'h3C, RHU, 4'h7, 1'b1, 1'b0);
    beat("cnt_c", 8'h3C, RHU, 4'h7, 1'b1, 1'b0);
    chk("cnt/three", sat_count, 16'd3);
    beat("cnt_d", 8'h3C, RHU, 4'h7, 1'b1, 1'b1);
    chk("cnt/clear_wins", sat_count, 16'd0);
    beat("cnt_e", 8'h3C, RHU, 4'h7, 1'b1, 1'b0);
    chk("cnt/after_clear", sat_count, 16'd1);

    // Backpressure: 6 beats, out_ready low in windows 3..7
    nxt = 0; got = 0; occ = 0; prev_stall = 1'b0; prev_data = '0;
    mode = TRUNC;
    for (int w = 0; w < 30 && got < 6; w++) begin
      out_ready = !(w >= 3 && w <= 7);
      in_valid  = (nxt < 6);
      in_data   = {4{8'((nxt + 1) * 8)}};
      #1;
      if (prev_stall) begin
        chk("bp/hold_valid", out_valid, 1'b1);
        chk("bp/hold_data", out_data, prev_data);
      end
      chk("bp/in_ready", in_ready, (occ < 2) || out_ready);
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (xf) begin
        chk("bp/data", out_data, {4{4'(got + 1)}});
        if (got == 0 || got >= 3) chk("bp/latency", w - acc_win[got], 2);
        $display("bp out beat %0d window %0d data=%h", got, w, out_data);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (acc) begin
        acc_win[nxt] = w;
        nxt++;
      end
      occ = occ + int'(acc) - int'(xf);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp/count", got, 6);
    chk("bp/cnt_unchanged", sat_count, 16'd1);

    // Asynchronous reset with two beats in flight
    in_valid = 1'b1;
    in_data  = {4{8'h3C}};
    mode     = RHU;
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst/out_valid", out_valid, 1'b0);
    chk("arst/out_sat", out_sat, 4'h0);
    chk("arst/sat_count", sat_count, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    beat("post_rst", 8'h2C, RNE, 4'h6, 1'b0, 1'b0);
    chk("arst/cnt_after", sat_count, 16'd0);

    // Counter saturation at all-ones
    in_valid  = 1'b1;
    in_data   = {4{8'h3C}};
    mode      = RHU;
    out_ready = 1'b1;
    repeat (65534) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("top/fffe", sat_count, 16'hFFFE);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("top/hold_ffff", sat_count, 16'hFFFF);
    chk("top/drained", out_valid, 1'b0);
    $display("counter top sat_count=%h", sat_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/round_sat_pipe.md
# round_sat_pipe

Parametrised, pipelined round-and-saturate unit for the multiplier outputs of the matrix-multiply datapath. It accepts LANES signed fixed-point products per beat, drops the redundant sign bit and F = IN_W-1-OUT_W fraction bits under a selectable rounding mode, and clamps each lane to the symmetric range. It sits between the multiplier array and the accumulator/output buffer. Flow is valid/ready on both sides, and the unit keeps a running saturation counter.

## Interface
- IN_W, 8: product width per lane (signed, two's complement); IN_W >= OUT_W+2
- OUT_W, 4: rounded width per lane (signed)
- LANES, 4: lanes per beat
- CNT_W, 16: saturation counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  2  rounding mode, sampled with in_data on accept: 0 TRUNC, 1 RHU, 2 RNE, 3 treated as RHU
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  LANES*IN_W  lane k at [k*IN_W +: IN_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*OUT_W  lane k at [k*OUT_W +: OUT_W]
- out_sat  out  LANES  per-lane "clamp applied" flag, aligned with out_data
- sat_clear  in  1  synchronous clear of sat_count
- sat_count  out  CNT_W  output beats with any lane saturated; sticks at all-ones

## Operation
- Per lane, x is signed IN_W and F = IN_W-1-OUT_W. The lane computes r = round(x / 2^F) at full precision, IN_W-F+1 bits, with no wrap.
- TRUNC: r = x >>> F (floor).
- RHU: r = (x + 2^(F-1)) >>> F (round half up, toward +inf).
- RNE: round to nearest. Ties go to the even r.
- Clamp: MAX = 2^(OUT_W-1)-1 and MIN = -MAX. The most-negative code (1 followed by zeros) is never produced.
- If r > MAX, output MAX and set sat. If r < MIN, output MIN and set sat. Otherwise output r[OUT_W-1:0] with sat = 0.
- The x = most-negative input (non-redundant sign) needs no special case. It always clamps to MIN with sat = 1.
- Stage 1 registers r and mode-independent data per lane. Stage 2 registers the clamped out_data and out_sat.
- The mode of each beat travels with that beat. A mode change between beats takes effect on the next accepted beat only.
- sat_count increments by 1 on each output transfer (out_valid & out_ready) where |out_sat is set. It holds at 2^CNT_W-1.
- When sat_clear and an increment occur in the same cycle, sat_clear wins and the count becomes 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_sat 0, sat_count 0, and both internal stage-valid flags 0.
- in_ready is high during reset release, because the pipe is empty.
- A beat accepted at edge N appears on out_valid/out_data after edge N+2 (latency 2) when out_ready is held high.
- Throughput is 1 beat/cycle.
- Stage advance rule: s2 loads when !s2_valid | out_ready. s1 loads when !s1_valid | s2 loads.
- in_ready = !s1_valid | s2 loads. This is a combinational path from out_ready and is permitted.
- While out_valid = 1 and out_ready = 0: out_data, out_sat and out_valid hold stable.
- Under backpressure the pipe holds at most 2 beats with no loss or duplication.
- in_data is not sampled when in_valid = 0 or in_ready = 0.
- Asserting rst_n low mid-stream clears both stages immediately. In-flight beats are discarded and not counted.

## Structure
- Shared package round_pkg holds:
  - localparams MODE_TRUNC = 2'd0, MODE_RHU = 2'd1, MODE_RNE = 2'd2
  - a function computing F from IN_W and OUT_W
  - an elaboration check IN_W >= OUT_W+2
- Sub-module round_lane is combinational: it implements the round step and the clamp step for one lane, parametrised by IN_W and OUT_W. It is instantiated LANES times in a generate loop.
- round_sat_pipe owns the two pipeline registers, the handshake and sat_count.

## Test plan
All scenarios use IN_W = 8, OUT_W = 4, F = 3, MAX = 7.
- Rounding, lane 0, x = 8'h2C (5.5): TRUNC -> 4'h5, RHU -> 4'h6, RNE -> 4'h6. For x = 8'h24 (4.5): RNE -> 4'h4, RHU -> 4'h5. out_sat = 0 in all cases.
- Positive saturation: x = 8'h3C (7.5) under RHU -> 4'h7, sat = 1, sat_count 0 -> 1. The same x under TRUNC -> 4'h7, sat = 0.
- Negative clamp: x = 8'hC4 (-7.5) RHU -> 4'h9 (-7), sat = 0. TRUNC -> 4'h9, sat = 1. x = 8'hC0 -> 4'h9, sat = 1. x = 8'h80 -> 4'h9, sat = 1. 4'h8 never appears.
- Backpressure: stream 6 beats with out_ready held low for cycles 3-7. Required response:
  - in_ready drops after 2 beats are held
  - outputs stay stable while stalled
  - all 6 beats emerge in order, each 2 cycles after acceptance when unstalled
- Counter: 3 saturating beats, then sat_clear in the same cycle as a 4th saturating transfer -> count 0. Separately, preload toward the top and verify it holds at 16'hFFFF.
- Reset: pull rst_n low with 2 beats in flight. Required response: out_valid 0 asynchronously, sat_count 0, and after release the first new beat emerges at latency 2 with no stale data.
